// File: rtl/instr_pkg.sv
// rtl/instr_pkg.sv - shared types and field positions for the instruction encoder/loader
// Contents: op-class enum, instruction field bit positions, loader FSM state enum.
package instr_pkg;

   typedef enum logic [1:0] {
      OP_DP  = 2'b00,
      OP_MEM = 2'b01,
      OP_BR  = 2'b10,
      OP_ILL = 2'b11
   } op_e;

   // Fields common to every class
   localparam int COND_HI = 31;
   localparam int COND_LO = 28;
   localparam int OP_HI   = 27;
   localparam int OP_LO   = 26;
   localparam int I_POS   = 25;

   // Data-processing
   localparam int OPC_HI  = 24;
   localparam int OPC_LO  = 21;
   localparam int S_POS   = 20;

   // Memory
   localparam int P_POS   = 24;
   localparam int U_POS   = 23;
   localparam int B_POS   = 22;
   localparam int W_POS   = 21;
   localparam int L1_POS  = 20;

   // Register fields and 12-bit operand (data-processing and memory)
   localparam int RN_HI   = 19;
   localparam int RN_LO   = 16;
   localparam int RD_HI   = 15;
   localparam int RD_LO   = 12;
   localparam int IMM_HI  = 11;
   localparam int IMM_LO  = 0;

   // Branch
   localparam int L2_POS  = 24;
   localparam int BOFF_HI = 23;
   localparam int BOFF_LO = 0;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_WRITE = 1'b1
   } state_e;

endpackage

// File: rtl/instr_packer.sv
// rtl/instr_packer.sv - combinational field-to-word instruction packer
// Inputs: cond, op, i_bit, opcode, s_bit, p, u, b, w, l1, l2, rn, rd,
//         operand2, offset_std, offset_branch.
// Output: word, the packed 32-bit instruction (illegal class packs cond/op only).
module instr_packer
   import instr_pkg::*;
(
   input  logic [3:0]  cond,
   input  logic [1:0]  op,
   input  logic        i_bit,
   input  logic [3:0]  opcode,
   input  logic        s_bit,
   input  logic        p,
   input  logic        u,
   input  logic        b,
   input  logic        w,
   input  logic        l1,
   input  logic        l2,
   input  logic [3:0]  rn,
   input  logic [3:0]  rd,
   input  logic [11:0] operand2,
   input  logic [11:0] offset_std,
   input  logic [23:0] offset_branch,
   output logic [31:0] word
);

   always_comb begin
      word = '0;
      word[COND_HI:COND_LO] = cond;
      word[OP_HI:OP_LO]     = op;
      case (op_e'(op))
         OP_DP: begin
            word[I_POS]           = i_bit;
            word[OPC_HI:OPC_LO]   = opcode;
            word[S_POS]           = s_bit;
            word[RN_HI:RN_LO]     = rn;
            word[RD_HI:RD_LO]     = rd;
            word[IMM_HI:IMM_LO]   = operand2;
         end
         OP_MEM: begin
            word[I_POS]           = i_bit;
            word[P_POS]           = p;
            word[U_POS]           = u;
            word[B_POS]           = b;
            word[W_POS]           = w;
            word[L1_POS]          = l1;
            word[RN_HI:RN_LO]     = rn;
            word[RD_HI:RD_LO]     = rd;
            word[IMM_HI:IMM_LO]   = offset_std;
         end
         OP_BR: begin
            // Bit 25 is a fixed 1 in branch encodings
            word[I_POS]           = 1'b1;
            word[L2_POS]          = l2;
            word[BOFF_HI:BOFF_LO] = offset_branch;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - packs instruction fields and writes them to program memory
// Inputs:  clk, rst (async, active high), clear (sync restart), in_valid + field set.
// Outputs: in_ready, mem_we/mem_addr/mem_wdata (write port), count, full, err.
module instr_encoder_loader
   import instr_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        cond,
   input  logic [1:0]        op,
   input  logic              i_bit,
   input  logic [3:0]        opcode,
   input  logic              s_bit,
   input  logic              p,
   input  logic              u,
   input  logic              b,
   input  logic              w,
   input  logic              l1,
   input  logic              l2,
   input  logic [3:0]        rn,
   input  logic [3:0]        rd,
   input  logic [11:0]       operand2,
   input  logic [11:0]       offset_std,
   input  logic [23:0]       offset_branch,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              err
);

   state_e            state;
   logic [ADDR_W-1:0] wptr;
   logic [31:0]       packed_word;

   instr_packer u_packer (
      .cond          (cond),
      .op            (op),
      .i_bit         (i_bit),
      .opcode        (opcode),
      .s_bit         (s_bit),
      .p             (p),
      .u             (u),
      .b             (b),
      .w             (w),
      .l1            (l1),
      .l2            (l2),
      .rn            (rn),
      .rd            (rd),
      .operand2      (operand2),
      .offset_std    (offset_std),
      .offset_branch (offset_branch),
      .word          (packed_word)
   );

   // Moore decodes: acceptance only from IDLE with room left
   assign full     = (count == (ADDR_W+1)'(DEPTH));
   assign in_ready = (state == S_IDLE) && !full;
   assign mem_addr = wptr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         wptr      <= '0;
         count     <= '0;
         mem_we    <= 1'b0;
         mem_wdata <= '0;
         err       <= 1'b0;
      end else begin
         err <= 1'b0;
         if (clear) begin
            // A write already strobing this cycle completes; only the pointer is discarded
            state  <= S_IDLE;
            wptr   <= '0;
            count  <= '0;
            mem_we <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (in_valid && in_ready) begin
                     if (op_e'(op) == OP_ILL) begin
                        err <= 1'b1;
                     end else begin
                        mem_wdata <= packed_word;
                        mem_we    <= 1'b1;
                        state     <= S_WRITE;
                     end
                  end
               end
               S_WRITE: begin
                  mem_we <= 1'b0;
                  wptr   <= wptr + ADDR_W'(1);
                  count  <= count + (ADDR_W+1)'(1);
                  state  <= S_IDLE;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb/tb_instr_encoder_loader.sv - directed self-checking bench for instr_encoder_loader
module tb_instr_encoder_loader;

   localparam int ADDR_W = 4;
   localparam int DEPTH  = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              clear = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [3:0]        cond = '0;
   logic [1:0]        op = '0;
   logic              i_bit = 1'b0;
   logic [3:0]        opcode = '0;
   logic              s_bit = 1'b0;
   logic              p = 1'b0, u = 1'b0, b = 1'b0, w = 1'b0;
   logic              l1 = 1'b0, l2 = 1'b0;
   logic [3:0]        rn = '0, rd = '0;
   logic [11:0]       operand2 = '0, offset_std = '0;
   logic [23:0]       offset_branch = '0;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [ADDR_W:0]   count;
   logic              full;
   logic              err;

   int n_checks = 0;
   int n_errors = 0;

   instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
      .cond(cond), .op(op), .i_bit(i_bit), .opcode(opcode), .s_bit(s_bit),
      .p(p), .u(u), .b(b), .w(w), .l1(l1), .l2(l2), .rn(rn), .rd(rd),
      .operand2(operand2), .offset_std(offset_std), .offset_branch(offset_branch),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .count(count), .full(full), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic set_dp(input logic [3:0] c, input logic ib, input logic [3:0] opc,
                         input logic sb, input logic [3:0] n, input logic [3:0] d,
                         input logic [11:0] o2);
      cond = c; op = 2'b00; i_bit = ib; opcode = opc; s_bit = sb;
      rn = n; rd = d; operand2 = o2;
   endtask

   task automatic set_mem(input logic [3:0] c, input logic ib, input logic pp, input logic uu,
                          input logic bb, input logic ww, input logic ll,
                          input logic [3:0] n, input logic [3:0] d, input logic [11:0] off);
      cond = c; op = 2'b01; i_bit = ib; p = pp; u = uu; b = bb; w = ww; l1 = ll;
      rn = n; rd = d; offset_std = off;
   endtask

   task automatic set_br(input logic [3:0] c, input logic link, input logic [23:0] off);
      cond = c; op = 2'b10; l2 = link; offset_branch = off;
   endtask

   // Called at a negedge; returns just after the accepting posedge with in_valid dropped
   task automatic handshake();
      bit ok = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 20 && !ok; i++) begin
         if (in_ready) begin
            @(posedge clk);
            ok = 1'b1;
         end else begin
            @(negedge clk);
         end
      end
      if (!ok) check("accept_timeout", 32'd0, 32'd1);
      #1 in_valid = 1'b0;
   endtask

   // Full write sequence: check the strobe cycle, then the count after it
   task automatic write_word(input string tag, input logic [ADDR_W-1:0] exp_addr,
                             input logic [31:0] exp_word, input logic [ADDR_W:0] exp_count);
      handshake();
      @(negedge clk);
      check({tag, "_we"}, 32'(mem_we), 32'd1);
      check({tag, "_addr"}, 32'(mem_addr), 32'(exp_addr));
      check({tag, "_wdata"}, mem_wdata, exp_word);
      check({tag, "_rdy_low"}, 32'(in_ready), 32'd0);
      @(negedge clk);
      check({tag, "_we_off"}, 32'(mem_we), 32'd0);
      check({tag, "_count"}, 32'(count), 32'(exp_count));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #12;
      check("rst_ready", 32'(in_ready), 32'd1);
      check("rst_we", 32'(mem_we), 32'd0);
      check("rst_addr", 32'(mem_addr), 32'd0);
      check("rst_wdata", mem_wdata, 32'd0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_full", 32'(full), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      set_dp(4'hE, 1'b1, 4'h4, 1'b0, 4'h1, 4'h2, 12'h005);
      write_word("dp", 4'd0, 32'hE2812005, 5'd1);

      // Illegal class: err for one cycle, nothing written
      op = 2'b11;
      handshake();
      @(negedge clk);
      check("ill_err", 32'(err), 32'd1);
      check("ill_we", 32'(mem_we), 32'd0);
      @(negedge clk);
      check("ill_err_off", 32'(err), 32'd0);
      check("ill_count", 32'(count), 32'd1);

      set_mem(4'hE, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'h3, 4'h4, 12'h008);
      write_word("ldr", 4'd1, 32'hE5934008, 5'd2);

      set_br(4'hE, 1'b0, 24'hFFFFFE);
      write_word("b", 4'd2, 32'hEAFFFFFE, 5'd3);

      set_br(4'hE, 1'b1, 24'hFFFFFE);
      write_word("bl", 4'd3, 32'hEBFFFFFE, 5'd4);
      check("full_set", 32'(full), 32'd1);
      check("full_rdy", 32'(in_ready), 32'd0);

      // Fifth word held off while full
      set_dp(4'h0, 1'b0, 4'hD, 1'b1, 4'h0, 4'h7, 12'h0A5);
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("hold_we", 32'(mem_we), 32'd0);
         check("hold_count", 32'(count), 32'd4);
      end

      clear = 1'b1;
      @(posedge clk);
      #1 clear = 1'b0;
      @(negedge clk);
      check("clr_count", 32'(count), 32'd0);
      check("clr_full", 32'(full), 32'd0);
      check("clr_rdy", 32'(in_ready), 32'd1);
      // Held word now accepted: 0000 00 0 1101 1 0000 0111 0A5
      write_word("after_clr", 4'd0, 32'h01B070A5, 5'd1);

      // Asynchronous reset during the WRITE cycle
      set_dp(4'h1, 1'b0, 4'h2, 1'b1, 4'h5, 4'h6, 12'h123);
      handshake();
      @(negedge clk);
      check("pre_rst_we", 32'(mem_we), 32'd1);
      check("pre_rst_addr", 32'(mem_addr), 32'd1);
      rst = 1'b1;
      #1;
      check("async_we", 32'(mem_we), 32'd0);
      check("async_addr", 32'(mem_addr), 32'd0);
      check("async_wdata", mem_wdata, 32'd0);
      check("async_count", 32'(count), 32'd0);
      check("async_rdy", 32'(in_ready), 32'd1);
      check("async_err", 32'(err), 32'd0);
      #1 rst = 1'b0;
      @(negedge clk);
      set_br(4'hA, 1'b1, 24'h000010);
      write_word("post_rst", 4'd0, 32'hAB000010, 5'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/instr_encoder_loader.md
# instr_encoder_loader

Writer-side counterpart of the instruction decode path. Accepts instruction fields (condition, op class, data-processing, load/store and branch fields) over a valid/ready handshake. Packs them into a 32-bit ARM-style instruction word and writes it into the instruction memory at an auto-incrementing address. This lets benches and boot logic fill program memory that the fetch counter and decoder later read back.

## Interface
Parameters:
- ADDR_W, 8, instruction memory address width.
- DEPTH, 256, number of writable words (must be ≤ 2**ADDR_W).

Ports (all outputs registered or Moore-decoded from state):
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous restart: write pointer and count return to 0.
- in_valid  in  1  field set is valid.
- in_ready  out  1  block can accept a field set.
- cond  in  4  condition code.
- op  in  2  instruction class: 00 data-processing, 01 memory, 10 branch, 11 illegal.
- i_bit  in  1  immediate flag.
- opcode  in  4  data-processing opcode.
- s_bit  in  1  set-flags bit.
- p, u, b, w  in  1 each  memory addressing bits.
- l1  in  1  load/store select (memory class).
- l2  in  1  link bit (branch class).
- rn, rd  in  4 each  register numbers.
- operand2  in  12  data-processing operand 2.
- offset_std  in  12  memory offset.
- offset_branch  in  24  branch offset.
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  32  encoded instruction.
- count  out  ADDR_W+1  words written since reset/clear.
- full  out  1  count == DEPTH.
- err  out  1  one-cycle pulse on an illegal op.

## Operation
- Encoding, by class. Bits [31:28]=cond and [27:26]=op in every class.
  - Data-processing: [25]=i_bit, [24:21]=opcode, [20]=s_bit, [19:16]=rn, [15:12]=rd, [11:0]=operand2.
  - Memory: [25]=i_bit, [24]=p, [23]=u, [22]=b, [21]=w, [20]=l1, [19:16]=rn, [15:12]=rd, [11:0]=offset_std.
  - Branch: [25]=1 (constant), [24]=l2, [23:0]=offset_branch.
- FSM states:
  - IDLE: in_ready = !full. On in_valid && in_ready:
    - op != 11: latch the packed word into mem_wdata and go to WRITE.
    - op == 11: pulse err for the next cycle, no write, stay in IDLE.
  - WRITE: mem_we=1, mem_addr=wptr, in_ready=0. On exit, wptr and count increment and the FSM returns to IDLE.
- full=1 blocks acceptance; held-off fields must stay stable until accepted.
- clear has priority in every state. Next state is IDLE and wptr=count=0. If clear arrives while in WRITE, that cycle's write still occurs, but the pointer does not advance.
- wptr wraps only through clear. It never exceeds DEPTH-1 because full blocks acceptance.

## Timing
- Reset values: state IDLE, in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, count=0, full=0, err=0.
- Handshake at edge N gives mem_we=1 with valid addr/data during cycle N+1. Count updates at edge N+1.
- Throughput is one word per 2 cycles. in_ready is low during WRITE.
- An illegal op accepted at edge N gives err=1 during cycle N+1 only. count is unchanged.
- full rises in the same cycle count reaches DEPTH.
- rst asserted mid-WRITE aborts the write immediately. mem_we drops asynchronously and the memory is not written.

## Structure
- The shared package instr_pkg holds:
  - Op-class enum (OP_DP, OP_MEM, OP_BR, OP_ILL).
  - Field bit-position constants.
  - The FSM state enum.
- Sub-module instr_packer: purely combinational field-to-word packing, reusable by benches as a golden model.

## Test plan
- DP word: cond=E, op=00, i_bit=1, opcode=4, s_bit=0, rn=1, rd=2, operand2=005 → mem_we one cycle later with addr 0, wdata 0xE2812005; count becomes 1.
- LDR word: cond=E, op=01, i_bit=0, p=1, u=1, b=0, w=0, l1=1, rn=3, rd=4, offset_std=008 → wdata 0xE5934008 at addr 1.
- Branch word: cond=E, op=10, l2=0, offset_branch=FFFFFE → wdata 0xEAFFFFFE. With l2=1 → 0xEBFFFFFE.
- Illegal op=11 → err high exactly one cycle, mem_we stays 0, count unchanged.
- With DEPTH=4: four writes → full=1 and in_ready=0, and a fifth valid is held off. Pulse clear → count=0, and the next write lands at addr 0.
- Assert rst during WRITE → mem_we falls without waiting for a clock edge; all outputs return to reset values; the next accepted word goes to addr 0.
